// File: rtl/keypad_bcd_entry_if.sv
// Signal bundle between the keypad scanner and its consumers:
// keypad matrix lines plus the key/entry/value outputs.
`timescale 1ns/1ps
interface keypad_bcd_entry_if;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic        KeyValid;
   logic [3:0]  KeyCode;
   logic [3:0]  Digit1000;
   logic [3:0]  Digit100;
   logic [3:0]  Digit10;
   logic [3:0]  Digit1;
   logic [13:0] Value;
   logic        Load;

   modport master (
      input  ROW,
      output COL, KeyValid, KeyCode, Digit1000, Digit100, Digit10, Digit1, Value, Load
   );

   modport slave (
      output ROW,
      input  COL, KeyValid, KeyCode, Digit1000, Digit100, Digit10, Digit1, Value, Load
   );
endinterface

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with debounce, 4-digit BCD entry register and
// Enter-triggered binary conversion with a one-cycle load strobe.
`timescale 1ns/1ps
module keypad_bcd_entry #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic                 CLK100MHz,
   input  logic                 RST,
   keypad_bcd_entry_if.master   kp
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int TW       = $clog2(TICK_DIV);
   localparam int CW       = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  rowMeta_q, rowSync_q;
   logic [TW-1:0] tickCnt_q;
   logic [1:0]  col_q, col_d;
   logic [1:0]  rowIdx_q, rowIdx_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]  d1000_q, d1000_d, d100_q, d100_d, d10_q, d10_d, d1_q, d1_d;
   logic [13:0] value_q, value_d;
   logic [3:0]  keyCode_q, keyCode_d;
   logic        keyValid_q, keyValid_d;
   logic        load_q, load_d;

   logic        tick;
   logic        anyLow;
   logic        sameRowLow;
   logic [1:0]  firstRow;
   logic [3:0]  pressCode;
   logic [13:0] entrySum;

   function automatic logic [3:0] keyLookup(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign tick       = (tickCnt_q == TICK_LAST);
   assign anyLow     = ~&rowSync_q;
   assign sameRowLow = ~rowSync_q[rowIdx_q];
   assign pressCode  = keyLookup(rowIdx_q, col_q);
   assign entrySum   = 14'(d1000_q) * 14'd1000 + 14'(d100_q) * 14'd100
                     + 14'(d10_q) * 14'd10 + 14'(d1_q);

   // Lowest-index low row wins when several rows are pulled down
   always_comb begin
      firstRow = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!rowSync_q[r]) firstRow = 2'(r);
      end
   end

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      rowIdx_d   = rowIdx_q;
      count_d    = count_q;
      d1000_d    = d1000_q;
      d100_d     = d100_q;
      d10_d      = d10_q;
      d1_d       = d1_q;
      value_d    = value_q;
      keyCode_d  = keyCode_q;
      keyValid_d = 1'b0;
      load_d     = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (anyLow) begin
                  rowIdx_d = firstRow;
                  count_d  = '0;
                  state_d  = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (sameRowLow) begin
                  count_d = count_q + CW'(1);
                  if (count_q + CW'(1) == DB_LAST) begin
                     // Accept the key: strobe and key action share this edge
                     state_d    = HOLD;
                     keyValid_d = 1'b1;
                     keyCode_d  = pressCode;
                     if (pressCode <= 4'd9) begin
                        d1000_d = d100_q;
                        d100_d  = d10_q;
                        d10_d   = d1_q;
                        d1_d    = pressCode;
                     end else if (pressCode == 4'hE) begin
                        d1000_d = 4'd0;
                        d100_d  = 4'd0;
                        d10_d   = 4'd0;
                        d1_d    = 4'd0;
                     end else if (pressCode == 4'hF) begin
                        value_d = entrySum;
                        load_d  = 1'b1;
                     end
                  end
               end else begin
                  state_d = SCAN;
               end
            end
            HOLD: begin
               if (!anyLow) begin
                  count_d = '0;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (!anyLow) begin
                  count_d = count_q + CW'(1);
                  if (count_q + CW'(1) == DB_LAST) begin
                     state_d = SCAN;
                     col_d   = col_q + 2'd1;
                  end
               end else begin
                  state_d = HOLD;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // Synchronizer, scan timebase and all architectural state
   always_ff @(posedge CLK100MHz) begin
      if (RST) begin
         state_q    <= SCAN;
         rowMeta_q  <= 4'hF;
         rowSync_q  <= 4'hF;
         tickCnt_q  <= '0;
         col_q      <= 2'd0;
         rowIdx_q   <= 2'd0;
         count_q    <= '0;
         d1000_q    <= 4'd0;
         d100_q     <= 4'd0;
         d10_q      <= 4'd0;
         d1_q       <= 4'd0;
         value_q    <= 14'd0;
         keyCode_q  <= 4'd0;
         keyValid_q <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rowMeta_q  <= kp.ROW;
         rowSync_q  <= rowMeta_q;
         tickCnt_q  <= tick ? '0 : tickCnt_q + TW'(1);
         col_q      <= col_d;
         rowIdx_q   <= rowIdx_d;
         count_q    <= count_d;
         d1000_q    <= d1000_d;
         d100_q     <= d100_d;
         d10_q      <= d10_d;
         d1_q       <= d1_d;
         value_q    <= value_d;
         keyCode_q  <= keyCode_d;
         keyValid_q <= keyValid_d;
         load_q     <= load_d;
      end
   end

   assign kp.COL       = ~(4'b0001 << col_q);
   assign kp.KeyValid  = keyValid_q;
   assign kp.KeyCode   = keyCode_q;
   assign kp.Digit1000 = d1000_q;
   assign kp.Digit100  = d100_q;
   assign kp.Digit10   = d10_q;
   assign kp.Digit1    = d1_q;
   assign kp.Value     = value_q;
   assign kp.Load      = load_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: a keypad matrix model, a vector table,
// randomized key entry against an integer entry model, and corner sequences.
`timescale 1ns/1ps
module tb_keypad_bcd_entry;

   localparam int CLK_HZ = 1000;
   localparam int SCAN_HZ = 100;
   localparam int DB = 3;

   typedef struct {
      logic [3:0] key;
      int         holdClk;
      int         relClk;
      int         expPulses;
      logic [3:0] expCode;
      logic [15:0] expDigits;
      int         expValue;
      int         expLoads;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] pressed [4];
   logic [3:0] rowDrive;
   logic [15:0] digitsNow;

   int vectors = 0;
   int miscompares = 0;
   int kvCount = 0;
   int ldCount = 0;
   logic [3:0] lastCode = 4'h0;
   logic prevKv = 1'b0;

   keypad_bcd_entry_if kbIf ();

   keypad_bcd_entry #(
      .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_TICKS(DB)
   ) dut (
      .CLK100MHz(clk),
      .RST(rst),
      .kp(kbIf.master)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key shorts its row to its column while driven low
   always_comb begin
      rowDrive = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r][c] && !kbIf.COL[c]) rowDrive[r] = 1'b0;
         end
      end
   end
   assign kbIf.ROW = rowDrive;
   assign digitsNow = {kbIf.Digit1000, kbIf.Digit100, kbIf.Digit10, kbIf.Digit1};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] keyPos(input logic [3:0] k);
      case (k)
         4'h1: return 4'h0;  4'h2: return 4'h1;  4'h3: return 4'h2;  4'hA: return 4'h3;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'hB: return 4'h7;
         4'h7: return 4'h8;  4'h8: return 4'h9;  4'h9: return 4'hA;  4'hC: return 4'hB;
         4'hE: return 4'hC;  4'h0: return 4'hD;  4'hF: return 4'hE;  default: return 4'hF;
      endcase
   endfunction

   task automatic setKey(input logic [3:0] k, input logic v);
      logic [3:0] p;
      p = keyPos(k);
      pressed[p[3:2]][p[1:0]] = v;
   endtask

   task automatic applyStimulus(input logic [3:0] k, input int holdClk, input int relClk);
      setKey(k, 1'b1);
      repeat (holdClk) @(negedge clk);
      setKey(k, 1'b0);
      repeat (relClk) @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse bookkeeping, sampled on the falling edge
   always @(negedge clk) begin
      if (kbIf.KeyValid) begin
         kvCount++;
         lastCode = kbIf.KeyCode;
         checkOutput("kv_width", {31'b0, prevKv}, 32'd0);
      end
      if (kbIf.Load) begin
         ldCount++;
         checkOutput("load_needs_kv", {31'b0, kbIf.KeyValid}, 32'd1);
      end
      prevKv = kbIf.KeyValid;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t tbl [8];
      int kv0, ld0, entry, value, expLd, expPulses, waited;
      logic [3:0] k;
      logic [15:0] expDig;

      tbl[0] = '{4'h1, 100, 100, 1, 4'h1, 16'h0001, 0, 0};
      tbl[1] = '{4'h2, 100, 100, 1, 4'h2, 16'h0012, 0, 0};
      tbl[2] = '{4'h3, 100, 100, 1, 4'h3, 16'h0123, 0, 0};
      tbl[3] = '{4'h4, 100, 100, 1, 4'h4, 16'h1234, 0, 0};
      tbl[4] = '{4'hF, 100, 100, 1, 4'hF, 16'h1234, 1234, 1};
      tbl[5] = '{4'h5, 100, 100, 1, 4'h5, 16'h2345, 1234, 0};
      tbl[6] = '{4'hE, 100, 100, 1, 4'hE, 16'h0000, 1234, 0};
      tbl[7] = '{4'hA, 100, 100, 1, 4'hA, 16'h0000, 1234, 0};

      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
      @(negedge clk);
      doReset();

      checkOutput("reset_digits", {16'b0, digitsNow}, 32'h0);
      checkOutput("reset_value", {18'b0, kbIf.Value}, 32'd0);
      checkOutput("reset_kv", {31'b0, kbIf.KeyValid}, 32'd0);
      checkOutput("reset_load", {31'b0, kbIf.Load}, 32'd0);
      checkOutput("reset_code", {28'b0, kbIf.KeyCode}, 32'd0);
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0 || i % 10 == 9) begin
            checkOutput($sformatf("col_rotate_%0d", i), {28'b0, kbIf.COL},
                        {28'b0, ~(4'b0001 << (i / 10))});
         end
         @(negedge clk);
      end

      for (int i = 0; i < 8; i++) begin
         kv0 = kvCount;
         ld0 = ldCount;
         applyStimulus(tbl[i].key, tbl[i].holdClk, tbl[i].relClk);
         checkOutput($sformatf("tbl%0d_pulses", i), kvCount - kv0, tbl[i].expPulses);
         checkOutput($sformatf("tbl%0d_code", i), {28'b0, lastCode}, {28'b0, tbl[i].expCode});
         checkOutput($sformatf("tbl%0d_digits", i), {16'b0, digitsNow}, {16'b0, tbl[i].expDigits});
         checkOutput($sformatf("tbl%0d_value", i), {18'b0, kbIf.Value}, tbl[i].expValue);
         checkOutput($sformatf("tbl%0d_loads", i), ldCount - ld0, tbl[i].expLoads);
      end

      // Randomized entry against an integer model of the 4-digit register
      entry = 0;
      value = 1234;
      for (int i = 0; i < 24; i++) begin
         k = 4'($urandom_range(0, 15));
         kv0 = kvCount;
         ld0 = ldCount;
         expLd = 0;
         applyStimulus(k, $urandom_range(90, 150), $urandom_range(70, 120));
         if (k <= 4'd9) entry = (entry * 10 + int'(k)) % 10000;
         else if (k == 4'hE) entry = 0;
         else if (k == 4'hF) begin
            value = entry;
            expLd = 1;
         end
         expDig = {4'((entry / 1000) % 10), 4'((entry / 100) % 10),
                   4'((entry / 10) % 10), 4'(entry % 10)};
         checkOutput($sformatf("rnd%0d_pulses", i), kvCount - kv0, 32'd1);
         checkOutput($sformatf("rnd%0d_code", i), {28'b0, lastCode}, {28'b0, k});
         checkOutput($sformatf("rnd%0d_digits", i), {16'b0, digitsNow}, {16'b0, expDig});
         checkOutput($sformatf("rnd%0d_value", i), {18'b0, kbIf.Value}, value);
         checkOutput($sformatf("rnd%0d_loads", i), ldCount - ld0, expLd);
      end

      // Short glitch on row1 while column 0 is driven, right after reset
      doReset();
      kv0 = kvCount;
      setKey(4'h4, 1'b1);
      repeat (15) @(negedge clk);
      setKey(4'h4, 1'b0);
      waited = 0;
      while (kbIf.COL != 4'b1101 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("glitch_scan_resumed", {31'b0, (kbIf.COL == 4'b1101)}, 32'd1);
      checkOutput("glitch_pulses", kvCount - kv0, 32'd0);

      // Bounce then a long hold yields one press
      kv0 = kvCount;
      for (int b = 0; b < 2; b++) begin
         setKey(4'h4, 1'b1);
         repeat (5) @(negedge clk);
         setKey(4'h4, 1'b0);
         repeat (5) @(negedge clk);
      end
      applyStimulus(4'h4, 200, 100);
      checkOutput("bounce_pulses", kvCount - kv0, 32'd1);
      checkOutput("bounce_code", {28'b0, lastCode}, 32'h4);
      checkOutput("bounce_digits", {16'b0, digitsNow}, 32'h0004);

      // Two keys in row2: column 0 is reached first after reset
      doReset();
      kv0 = kvCount;
      setKey(4'h7, 1'b1);
      setKey(4'h8, 1'b1);
      repeat (100) @(negedge clk);
      setKey(4'h7, 1'b0);
      setKey(4'h8, 1'b0);
      repeat (100) @(negedge clk);
      checkOutput("twokey_pulses", kvCount - kv0, 32'd1);
      checkOutput("twokey_code", {28'b0, lastCode}, 32'h7);
      checkOutput("twokey_digits", {16'b0, digitsNow}, 32'h0007);

      // Long hold: no auto-repeat
      kv0 = kvCount;
      applyStimulus(4'h9, 1000, 100);
      checkOutput("hold_pulses", kvCount - kv0, 32'd1);
      checkOutput("hold_digits", {16'b0, digitsNow}, 32'h0079);

      // Reset while debouncing a press, with entry 0099 pending
      doReset();
      applyStimulus(4'h9, 100, 100);
      applyStimulus(4'h9, 100, 100);
      checkOutput("pre_rst_digits", {16'b0, digitsNow}, 32'h0099);
      waited = 0;
      while (kbIf.COL == 4'b1110 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      while (kbIf.COL != 4'b1110 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("pre_rst_col_sync", {31'b0, (kbIf.COL == 4'b1110)}, 32'd1);
      kv0 = kvCount;
      setKey(4'h1, 1'b1);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      setKey(4'h1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_dbnc_digits", {16'b0, digitsNow}, 32'h0);
      checkOutput("rst_dbnc_col", {28'b0, kbIf.COL}, 32'hE);
      checkOutput("rst_dbnc_kv", {31'b0, kbIf.KeyValid}, 32'd0);
      checkOutput("rst_dbnc_code", {28'b0, kbIf.KeyCode}, 32'd0);
      checkOutput("rst_dbnc_value", {18'b0, kbIf.Value}, 32'd0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      expPulses = 0;
      checkOutput("rst_dbnc_no_kv", kvCount - kv0, expPulses);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
